// File: rtl/multdiv_scheduler_if.sv
// Bundle between decode, the scheduler and the shared mult/div unit.
// The scheduler uses the slave modport; the environment drives through master.
interface multdiv_scheduler_if;
  logic        flush;
  logic        req_top;
  logic        req_bot;
  logic        div_top;
  logic        div_bot;
  logic [31:0] opA_top;
  logic [31:0] opB_top;
  logic [31:0] opA_bot;
  logic [31:0] opB_bot;
  logic [4:0]  rd_top;
  logic [4:0]  rd_bot;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall_top;
  logic        stall_bot;
  logic        wb_valid;
  logic        wb_slot;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        busy;

  modport slave (
    input  flush, req_top, req_bot, div_top, div_bot,
    input  opA_top, opB_top, opA_bot, opB_bot, rd_top, rd_bot,
    input  md_result, md_exception, md_resultRDY,
    output md_opA, md_opB, md_ctrl_mult, md_ctrl_div,
    output stall_top, stall_bot,
    output wb_valid, wb_slot, wb_rd, wb_data, wb_exception, busy
  );

  modport master (
    output flush, req_top, req_bot, div_top, div_bot,
    output opA_top, opB_top, opA_bot, opB_bot, rd_top, rd_bot,
    output md_result, md_exception, md_resultRDY,
    input  md_opA, md_opB, md_ctrl_mult, md_ctrl_div,
    input  stall_top, stall_bot,
    input  wb_valid, wb_slot, wb_rd, wb_data, wb_exception, busy
  );
endinterface

// File: rtl/multdiv_scheduler.sv
// Arbiter/sequencer for the shared multi-cycle mult/div unit (top slot wins).
// Define MULTDIV_TIMEOUT_EN to abort a WAIT that never sees md_resultRDY.
module multdiv_scheduler #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input logic                clk,
  input logic                rst,
  multdiv_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] wbData;
  logic [4:0]  rdLat;
  logic        slot;
  logic        wbExc;
  logic        multPulse;
  logic        divPulse;
  logic        wbValid;
  logic        busyNow;
  logic        takeTop;
  logic        takeBot;
`ifdef MULTDIV_TIMEOUT_EN
  logic [CNT_W-1:0] waitCnt;
`endif

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : gCntTooNarrow
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  // A flushed request is never accepted, whichever slot it sits in.
  assign takeTop = bus.req_top & ~bus.flush;
  assign takeBot = bus.req_bot & ~bus.req_top & ~bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      opA       <= '0;
      opB       <= '0;
      wbData    <= '0;
      rdLat     <= '0;
      slot      <= 1'b0;
      wbExc     <= 1'b0;
      multPulse <= 1'b0;
      divPulse  <= 1'b0;
      wbValid   <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      waitCnt   <= '0;
`endif
    end else begin
      multPulse <= 1'b0;
      divPulse  <= 1'b0;
      wbValid   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (takeTop) begin
            opA       <= bus.opA_top;
            opB       <= bus.opB_top;
            rdLat     <= bus.rd_top;
            slot      <= 1'b0;
            multPulse <= ~bus.div_top;
            divPulse  <= bus.div_top;
            state     <= ISSUE;
          end else if (takeBot) begin
            opA       <= bus.opA_bot;
            opB       <= bus.opB_bot;
            rdLat     <= bus.rd_bot;
            slot      <= 1'b1;
            multPulse <= ~bus.div_bot;
            divPulse  <= bus.div_bot;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= bus.flush ? IDLE : WAIT;
`ifdef MULTDIV_TIMEOUT_EN
          waitCnt <= '0;
`endif
        end
        WAIT: begin
          // flush beats ready; ready beats the timeout limit
          if (bus.flush) begin
            state <= IDLE;
          end else if (bus.md_resultRDY) begin
            wbData  <= bus.md_result;
            wbExc   <= bus.md_exception;
            wbValid <= 1'b1;
            state   <= DONE;
`ifdef MULTDIV_TIMEOUT_EN
          end else if (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            wbData  <= '0;
            wbExc   <= 1'b1;
            wbValid <= 1'b1;
            state   <= DONE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
`endif
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busyNow = (state != IDLE);

  // A flush landing in the pulse or write-back cycle kills that cycle's strobe.
  assign bus.md_ctrl_mult = multPulse & ~bus.flush;
  assign bus.md_ctrl_div  = divPulse & ~bus.flush;
  assign bus.wb_valid     = wbValid & ~bus.flush;
  assign bus.md_opA       = opA;
  assign bus.md_opB       = opB;
  assign bus.wb_slot      = slot;
  assign bus.wb_rd        = rdLat;
  assign bus.wb_data      = wbData;
  assign bus.wb_exception = wbExc;
  assign bus.busy         = busyNow;
  assign bus.stall_top    = bus.req_top & busyNow;
  assign bus.stall_bot    = bus.req_bot & (busyNow | bus.req_top);
endmodule

// File: tb/tb_multdiv_scheduler.sv
// Self-checking bench for multdiv_scheduler: vector table, directed corner
// sequences, and a randomized run against a transaction-level model.
module tb_multdiv_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multdiv_scheduler_if mdIf ();

  multdiv_scheduler #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(mdIf)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          bot;
    bit          dv;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] expData;
    bit          expExc;
  } vec_t;

  typedef struct {
    bit          dv;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } op_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behaviour of the unit itself: unsigned ops, divide-by-zero flags an exception.
  function automatic logic [32:0] unitCalc(input bit dv, input logic [31:0] a, input logic [31:0] b);
    if (!dv) return {1'b0, a * b};
    if (b == 0) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, a / b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input bit cm, input bit cd, input bit wv,
                     input bit bz, input bit st, input bit sb);
    @(negedge clk);
    check($sformatf("%s.ctrl_mult", tag), mdIf.md_ctrl_mult, cm);
    check($sformatf("%s.ctrl_div", tag), mdIf.md_ctrl_div, cd);
    check($sformatf("%s.wb_valid", tag), mdIf.wb_valid, wv);
    check($sformatf("%s.busy", tag), mdIf.busy, bz);
    check($sformatf("%s.stall_top", tag), mdIf.stall_top, st);
    check($sformatf("%s.stall_bot", tag), mdIf.stall_bot, sb);
  endtask

  task automatic checkAllZero(input string tag);
    check($sformatf("%s.busy", tag), mdIf.busy, 0);
    check($sformatf("%s.opA", tag), mdIf.md_opA, 0);
    check($sformatf("%s.opB", tag), mdIf.md_opB, 0);
    check($sformatf("%s.pulses", tag), {mdIf.md_ctrl_mult, mdIf.md_ctrl_div}, 0);
    check($sformatf("%s.wb_valid", tag), mdIf.wb_valid, 0);
    check($sformatf("%s.wb_slot", tag), mdIf.wb_slot, 0);
    check($sformatf("%s.wb_rd", tag), mdIf.wb_rd, 0);
    check($sformatf("%s.wb_data", tag), mdIf.wb_data, 0);
    check($sformatf("%s.wb_exc", tag), mdIf.wb_exception, 0);
  endtask

  task automatic driveTop(input bit req, input bit dv, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    mdIf.req_top = req; mdIf.div_top = dv; mdIf.opA_top = a; mdIf.opB_top = b; mdIf.rd_top = rd;
  endtask

  task automatic driveBot(input bit req, input bit dv, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    mdIf.req_bot = req; mdIf.div_bot = dv; mdIf.opA_bot = a; mdIf.opB_bot = b; mdIf.rd_bot = rd;
  endtask

  task automatic setRdy(input bit rdy, input logic [32:0] res);
    mdIf.md_resultRDY = rdy;
    {mdIf.md_exception, mdIf.md_result} = res;
  endtask

  task automatic runOp(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    if (v.bot) driveBot(1, v.dv, v.a, v.b, v.rd); else driveTop(1, v.dv, v.a, v.b, v.rd);
    cyc({t, ".acc"}, 0, 0, 0, 0, 0, 0);
    step();
    driveTop(0, 0, 0, 0, 0); driveBot(0, 0, 0, 0, 0);
    cyc({t, ".iss"}, !v.dv, v.dv, 0, 1, 0, 0);
    check({t, ".opA"}, mdIf.md_opA, v.a);
    check({t, ".opB"}, mdIf.md_opB, v.b);
    step();
    for (int i = 1; i < v.lat; i++) begin
      cyc({t, ".wait"}, 0, 0, 0, 1, 0, 0);
      step();
    end
    setRdy(1, unitCalc(v.dv, v.a, v.b));
    cyc({t, ".rdy"}, 0, 0, 0, 1, 0, 0);
    step();
    setRdy(0, {1'b1, $urandom});
    cyc({t, ".done"}, 0, 0, 1, 1, 0, 0);
    check({t, ".wb_slot"}, mdIf.wb_slot, v.bot);
    check({t, ".wb_rd"}, mdIf.wb_rd, v.rd);
    check({t, ".wb_data"}, mdIf.wb_data, v.expData);
    check({t, ".wb_exc"}, mdIf.wb_exception, v.expExc);
    $display("txn %s slot=%0d rd=%0d data=%h exc=%0d", t, mdIf.wb_slot, mdIf.wb_rd,
             mdIf.wb_data, mdIf.wb_exception);
    step();
    cyc({t, ".idle"}, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  // Randomized run against a transaction-level model of the arbitration rules.
  task automatic randomRun(input int nCycles);
    op_t topOp, botOp, cur;
    bit topPend = 0, botPend = 0, mBusy = 0, mDone = 0, curSlot = 0, rdyNow;
    int mAge = 0, rdyAt = -1, txns = 0;
    logic [32:0] mRes = '0;
    for (int c = 0; c < nCycles; c++) begin
      if (!topPend && $urandom_range(0, 3) == 0) begin
        topOp = '{dv: 1'($urandom_range(0, 1)), a: $urandom, b: $urandom_range(0, 9),
                  rd: 5'($urandom)};
        topPend = 1;
      end
      if (!botPend && $urandom_range(0, 2) == 0) begin
        botOp = '{dv: 1'($urandom_range(0, 1)), a: $urandom, b: $urandom,
                  rd: 5'($urandom)};
        botPend = 1;
      end
      driveTop(topPend, topOp.dv, topOp.a, topOp.b, topOp.rd);
      driveBot(botPend, botOp.dv, botOp.a, botOp.b, botOp.rd);
      if (mBusy && !mDone && mAge >= 2) begin
        rdyNow = (c == rdyAt);
        setRdy(rdyNow, rdyNow ? unitCalc(cur.dv, cur.a, cur.b) : {1'b1, $urandom});
      end else begin
        rdyNow = 0;
        setRdy($urandom_range(0, 5) == 0, {1'($urandom), $urandom});
      end
      @(negedge clk);
      check("rnd.busy", mdIf.busy, mBusy);
      check("rnd.ctrl_mult", mdIf.md_ctrl_mult, mBusy && mAge == 1 && !cur.dv);
      check("rnd.ctrl_div", mdIf.md_ctrl_div, mBusy && mAge == 1 && cur.dv);
      check("rnd.stall_top", mdIf.stall_top, topPend && mBusy);
      check("rnd.stall_bot", mdIf.stall_bot, botPend && (mBusy || topPend));
      check("rnd.wb_valid", mdIf.wb_valid, mDone);
      if (mBusy && mAge == 1) check("rnd.opAB", {mdIf.md_opA, mdIf.md_opB}, {cur.a, cur.b});
      if (mDone) begin
        check("rnd.wb_slot", mdIf.wb_slot, curSlot);
        check("rnd.wb_rd", mdIf.wb_rd, cur.rd);
        check("rnd.wb_res", {mdIf.wb_exception, mdIf.wb_data}, mRes);
        $display("txn rnd%0d slot=%0d rd=%0d data=%h exc=%0d", txns, mdIf.wb_slot,
                 mdIf.wb_rd, mdIf.wb_data, mdIf.wb_exception);
        txns++;
      end
      @(posedge clk);
      if (!mBusy) begin
        if (topPend || botPend) begin
          curSlot = !topPend;
          cur = topPend ? topOp : botOp;
          if (topPend) topPend = 0; else botPend = 0;
          mBusy = 1; mAge = 1; mDone = 0;
          rdyAt = c + 1 + $urandom_range(1, 6);
        end
      end else if (mDone) begin
        mBusy = 0; mDone = 0;
      end else begin
        if (mAge >= 2 && rdyNow) begin
          mDone = 1;
          mRes = unitCalc(cur.dv, cur.a, cur.b);
        end
        mAge++;
      end
      #1;
    end
    driveTop(0, 0, 0, 0, 0); driveBot(0, 0, 0, 0, 0); setRdy(0, '0);
    check("rnd.txnCount", txns > 20, 1);
  endtask

  initial begin
    int busyCnt, seenWb, firstWb;
    vecs[0] = '{bot: 0, dv: 0, a: 7, b: 6, rd: 3, lat: 17, expData: 42, expExc: 0};
    vecs[1] = '{bot: 0, dv: 1, a: 100, b: 7, rd: 4, lat: 3, expData: 14, expExc: 0};
    vecs[2] = '{bot: 1, dv: 0, a: 2, b: 3, rd: 5, lat: 1, expData: 6, expExc: 0};
    vecs[3] = '{bot: 0, dv: 1, a: 5, b: 0, rd: 9, lat: 2, expData: 32'hFFFF_FFFF, expExc: 1};
    vecs[4] = '{bot: 1, dv: 1, a: 32'hFFFF_FFFF, b: 16, rd: 31, lat: 4, expData: 32'h0FFF_FFFF, expExc: 0};
    vecs[5] = '{bot: 0, dv: 0, a: 32'h0001_0000, b: 32'h0001_0000, rd: 1, lat: 1, expData: 0, expExc: 0};

    rst = 1;
    mdIf.flush = 0;
    driveTop(0, 0, 0, 0, 0); driveBot(0, 0, 0, 0, 0); setRdy(0, '0);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 0;
    step();

    for (int i = 0; i < 6; i++) runOp(vecs[i], i);

    // Simultaneous requests: top issued first, bottom held until the next IDLE.
    driveTop(1, 1, 100, 7, 4); driveBot(1, 0, 2, 3, 5);
    cyc("sim.acc", 0, 0, 0, 0, 0, 1); step();
    driveTop(0, 0, 0, 0, 0);
    cyc("sim.iss", 0, 1, 0, 1, 0, 1); step();
    cyc("sim.w1", 0, 0, 0, 1, 0, 1); step();
    setRdy(1, unitCalc(1, 100, 7));
    cyc("sim.w2", 0, 0, 0, 1, 0, 1); step();
    setRdy(0, '0);
    cyc("sim.done", 0, 0, 1, 1, 0, 1);
    check("sim.topData", {mdIf.wb_slot, mdIf.wb_rd, mdIf.wb_data}, {1'b0, 5'd4, 32'd14});
    $display("txn sim.top slot=%0d rd=%0d data=%h", mdIf.wb_slot, mdIf.wb_rd, mdIf.wb_data);
    step();
    cyc("sim.idle", 0, 0, 0, 0, 0, 0); step();
    driveBot(0, 0, 0, 0, 0);
    cyc("sim.botIss", 1, 0, 0, 1, 0, 0);
    check("sim.botOpA", mdIf.md_opA, 2);
    step();
    setRdy(1, unitCalc(0, 2, 3));
    cyc("sim.botW1", 0, 0, 0, 1, 0, 0); step();
    setRdy(0, '0);
    cyc("sim.botDone", 0, 0, 1, 1, 0, 0);
    check("sim.botData", {mdIf.wb_slot, mdIf.wb_rd, mdIf.wb_data}, {1'b1, 5'd5, 32'd6});
    $display("txn sim.bot slot=%0d rd=%0d data=%h", mdIf.wb_slot, mdIf.wb_rd, mdIf.wb_data);
    step();
    cyc("sim.end", 0, 0, 0, 0, 0, 0); step();

    // Flush in the third WAIT cycle, stale readies, then a fresh op.
    driveTop(1, 0, 4, 5, 7);
    cyc("fl.acc", 0, 0, 0, 0, 0, 0); step();
    driveTop(0, 0, 0, 0, 0);
    cyc("fl.iss", 1, 0, 0, 1, 0, 0); step();
    cyc("fl.w1", 0, 0, 0, 1, 0, 0); step();
    cyc("fl.w2", 0, 0, 0, 1, 0, 0); step();
    mdIf.flush = 1;
    cyc("fl.w3", 0, 0, 0, 1, 0, 0); step();
    mdIf.flush = 0;
    setRdy(1, 33'd20);
    cyc("fl.stale1", 0, 0, 0, 0, 0, 0); step();
    setRdy(0, '0);
    cyc("fl.stale2", 0, 0, 0, 0, 0, 0); step();
    driveTop(1, 0, 3, 3, 8);
    cyc("fl.acc2", 0, 0, 0, 0, 0, 0); step();
    driveTop(0, 0, 0, 0, 0);
    setRdy(1, 33'd20);
    cyc("fl.iss2", 1, 0, 0, 1, 0, 0); step();
    setRdy(0, '0);
    cyc("fl.w1b", 0, 0, 0, 1, 0, 0); step();
    setRdy(1, unitCalc(0, 3, 3));
    cyc("fl.w2b", 0, 0, 0, 1, 0, 0); step();
    setRdy(0, '0);
    cyc("fl.done", 0, 0, 1, 1, 0, 0);
    check("fl.data", {mdIf.wb_rd, mdIf.wb_data}, {5'd8, 32'd9});
    $display("txn fl.new rd=%0d data=%h", mdIf.wb_rd, mdIf.wb_data);
    step();
    cyc("fl.idle", 0, 0, 0, 0, 0, 0); step();

    // Flush while idle, during ISSUE and during DONE.
    mdIf.flush = 1; driveTop(1, 0, 1, 1, 2);
    cyc("fi.idle", 0, 0, 0, 0, 1'b0, 0); step();
    mdIf.flush = 0; driveTop(0, 0, 0, 0, 0);
    cyc("fi.notTaken", 0, 0, 0, 0, 0, 0); step();
    driveTop(1, 0, 2, 2, 2);
    cyc("fi.acc", 0, 0, 0, 0, 0, 0); step();
    driveTop(0, 0, 0, 0, 0); mdIf.flush = 1;
    cyc("fi.iss", 0, 0, 0, 1, 0, 0); step();
    mdIf.flush = 0;
    cyc("fi.back", 0, 0, 0, 0, 0, 0); step();
    driveTop(1, 1, 9, 3, 6);
    cyc("fd.acc", 0, 0, 0, 0, 0, 0); step();
    driveTop(0, 0, 0, 0, 0);
    cyc("fd.iss", 0, 1, 0, 1, 0, 0); step();
    setRdy(1, unitCalc(1, 9, 3));
    cyc("fd.w1", 0, 0, 0, 1, 0, 0); step();
    setRdy(0, '0); mdIf.flush = 1;
    cyc("fd.done", 0, 0, 0, 1, 0, 0); step();
    mdIf.flush = 0;
    cyc("fd.idle", 0, 0, 0, 0, 0, 0); step();

    // Asynchronous reset in the middle of WAIT.
    driveTop(1, 0, 11, 13, 17);
    cyc("rs.acc", 0, 0, 0, 0, 0, 0); step();
    driveTop(0, 0, 0, 0, 0);
    cyc("rs.iss", 1, 0, 0, 1, 0, 0); step();
    cyc("rs.w1", 0, 0, 0, 1, 0, 0);
    #2 rst = 1;
    #1 checkAllZero("rs.async");
    step();
    rst = 0;
    setRdy(1, 33'd143);
    cyc("rs.after1", 0, 0, 0, 0, 0, 0); step();
    setRdy(0, '0);
    cyc("rs.after2", 0, 0, 0, 0, 0, 0); step();

    // Unit that never answers.
    driveTop(1, 1, 50, 5, 12);
    cyc("to.acc", 0, 0, 0, 0, 0, 0); step();
    driveTop(0, 0, 0, 0, 0);
`ifdef MULTDIV_TIMEOUT_EN
    firstWb = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (mdIf.wb_valid && firstWb == 0) begin
        firstWb = k;
        check("to.wb", {mdIf.wb_exception, mdIf.wb_data, mdIf.wb_rd}, {1'b1, 32'd0, 5'd12});
      end
      step();
    end
    check("to.cycle", firstWb, 42);
`else
    busyCnt = 0; seenWb = 0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (mdIf.busy) busyCnt++;
      if (mdIf.wb_valid) seenWb++;
      step();
    end
    check("to.busyHeld", busyCnt, 110);
    check("to.noWb", seenWb, 0);
    mdIf.flush = 1; step(); mdIf.flush = 0;
`endif
    cyc("to.idle", 0, 0, 0, 0, 0, 0); step();

    randomRun(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
